wb_late_merge_stage: RTL and testbench
======================================

// Module: wb_late_merge_stage
// PURPOSE
//  Final pipeline stage: registers the MEM-stage bundle and muxes one of four result sources onto the register-file write port.
//  Adds a QDEPTH-entry queue for long-latency results (FPU div/sqrt, misses) that return out of band, arbitrated onto the single write port.
//  Exports a pending-address lookup and a stall request so issue logic can avoid WAW hazards and queue starvation.
// PARAMETERS
//  DW         32  data width of all result buses
//  AW         6   register address width
//  QDEPTH     4   late-result queue entries (>=1)
//  STARVE_MAX 3   consecutive pipeline-won cycles before the queue forces priority (>=1)
// PORTS
//  clk            in  1      clock, all state on rising edge
//  reset          in  1      synchronous, active-high
//  stall          in  1      1 = hold stage register
//  NextRegWE      in  1      pipeline write enable
//  NextRegWAddr   in  AW     pipeline destination
//  NextDInSrc     in  2      0=PC+4 1=ALU 2=FPU 3=MEM
//  NextPCPlusFour/NextALUOut/NextFPUOut/NextMEMDout  in DW  source operands
//  NextOpcode     in  6      opcode passthrough
//  NextFunct      in  6      function passthrough
//  LateValid      in  1      late result offered
//  LateAddr       in  AW     late destination
//  LateData       in  DW     late value
//  LateReady      out 1      queue can accept
//  PendAddrQ      in  AW     lookup address from issue
//  PendHit        out 1      PendAddrQ matches a queued entry
//  WBStallReq     out 1      upstream must drive stall=1 this cycle
//  RegWBWE        out 1      register-file write enable
//  RegWBAddr      out AW     write address
//  RegWBData      out DW     write data
//  RegWBSrcLate   out 1      1 = current write comes from the queue
//  Opcode         out 6      registered opcode
//  Function       out 6      registered funct
//  QueueCount     out clog2(QDEPTH+1)  occupancy
// BEHAVIOUR
//  Reset: all stage registers 0 except opcode=6'h15 (NOP). Queue count, read/write pointers and starve counter = 0.
//   Entry contents are don't-care. LateReady is forced 0 while reset=1. Reset mid-operation discards all queued entries silently.
//  Stage register: on each edge with !reset && !stall, loads all Next* inputs. With stall=1, it holds.
//  Pipeline result = mux(din_src) of registered sources. Stage-to-output latency is 1 cycle.
//  Queue handshake: enqueue on LateValid && LateReady. LateReady = (count<QDEPTH), taken from registered count only.
//   An offer while LateReady=0 is not taken; the producer holds it.
//   Pointers wrap QDEPTH-1 -> 0. An entry enqueued at edge N is eligible from cycle N+1. There is no bypass.
//  Arbitration (combinational):
//   force   = (count!=0) && (starve==STARVE_MAX)
//   use_q   = (count!=0) && (!reg_we || force)
//   RegWBWE = reg_we || (count!=0)
//   Addr/Data = queue head if use_q, else stage register. RegWBSrcLate = use_q.
//  Dequeue: pops on edge when use_q=1. Enqueue and dequeue in the same cycle leaves count unchanged.
//  WBStallReq = force && reg_we. Upstream must then assert stall in the same cycle.
//   The held instruction is not written this cycle and writes on a later one.
//  Starve counter:
//   +1 (saturating at STARVE_MAX) when count!=0 && reg_we && !use_q
//   cleared on any dequeue or when count==0
//  PendHit: OR over valid entries of (addr==PendAddrQ). It is combinational and excludes the entry being offered this cycle.
//   Issue logic stalls any writer to a hit address. This block does not reorder WAW.
//  A stage-register write repeated while stalled is idempotent and permitted.
//  Queue order is strictly FIFO.
// TESTING
//  T1 Reset: reset=1 for 2 cycles mid-drain with 3 entries queued.
//     -> RegWBWE=0, Opcode=6'h15, QueueCount=0, LateReady=0 during reset and 1 after. No late write appears afterward.
//  T2 Mux: WE=1, addr=5, PC+4/ALU/FPU/MEM=0x10/0x20/0x30/0x40, DInSrc=0..3 on successive cycles.
//     -> next cycles show RegWBData 0x10,0x20,0x30,0x40 with RegWBAddr=5. stall=1 with changing Next* -> outputs frozen.
//  T3 Fill (QDEPTH=4): reg_we=1 and STARVE_MAX large; push addr 1..4.
//     -> QueueCount=4, LateReady=0, PendHit=1 for PendAddrQ=3, 0 for 9. A 5th offer is held, not lost.
//  T4 Idle drain: reg_we=0, 2 entries (a=7,d=0xAA), (a=8,d=0xBB).
//     -> 2 consecutive cycles RegWBSrcLate=1 writing 7/0xAA then 8/0xBB. Then RegWBWE=0.
//  T5 Starvation (STARVE_MAX=3): 1 queued, reg_we=1 every cycle.
//     -> pipeline wins 3 cycles, then WBStallReq=1 and the queue head is written. The held instruction writes on the next cycle.
//  T6 Wrap: 10 cycles of simultaneous enqueue+dequeue with count=2.
//     -> QueueCount stays 2, writes emerge in enqueue order across pointer wrap.

Source files
------------

// File: rtl/wb_late_merge_stage.sv
// wb_late_merge_stage
//   Final pipeline stage. Registers the MEM-stage bundle and selects one of
//   four result sources for the register-file write port. Long-latency
//   results that arrive out of band (FPU div/sqrt, misses) wait in a small
//   FIFO and share the same write port. Pipeline writes win by default. The
//   queue takes the port when the pipeline has nothing to write, or when
//   the pipeline has won STARVE_MAX cycles in a row.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   stall                 hold the stage register
//   Next*                 MEM-stage bundle (we, addr, source select, four
//                         source operands, opcode, funct)
//   LateValid/Addr/Data   late-result offer; LateReady = queue can accept
//   PendAddrQ / PendHit   lookup: is this address waiting in the queue
//   WBStallReq            upstream must stall this cycle (queue forced)
//   RegWB*                register-file write port; RegWBSrcLate marks a
//                         queue-sourced write
//   Opcode, Function      registered passthroughs
//   QueueCount            queue occupancy
module wb_late_merge_stage #(
    parameter int DW         = 32,
    parameter int AW         = 6,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          NextRegWE,
    input  logic [AW-1:0]                 NextRegWAddr,
    input  logic [1:0]                    NextDInSrc,
    input  logic [DW-1:0]                 NextPCPlusFour,
    input  logic [DW-1:0]                 NextALUOut,
    input  logic [DW-1:0]                 NextFPUOut,
    input  logic [DW-1:0]                 NextMEMDout,
    input  logic [5:0]                    NextOpcode,
    input  logic [5:0]                    NextFunct,
    input  logic                          LateValid,
    input  logic [AW-1:0]                 LateAddr,
    input  logic [DW-1:0]                 LateData,
    output logic                          LateReady,
    input  logic [AW-1:0]                 PendAddrQ,
    output logic                          PendHit,
    output logic                          WBStallReq,
    output logic                          RegWBWE,
    output logic [AW-1:0]                 RegWBAddr,
    output logic [DW-1:0]                 RegWBData,
    output logic                          RegWBSrcLate,
    output logic [5:0]                    Opcode,
    output logic [5:0]                    Function,
    output logic [$clog2(QDEPTH+1)-1:0]   QueueCount
);

    localparam int CW = $clog2(QDEPTH+1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int SW = $clog2(STARVE_MAX+1);
    localparam logic [5:0] OP_NOP = 6'h15;

    // ---------------- stage register ----------------
    logic          reg_we;
    logic [AW-1:0] reg_waddr;
    logic [1:0]    din_src;
    logic [DW-1:0] pc4, alu_out, fpu_out, mem_out;
    logic [5:0]    opcode_q, funct_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_we    <= 1'b0;
            reg_waddr <= '0;
            din_src   <= '0;
            pc4       <= '0;
            alu_out   <= '0;
            fpu_out   <= '0;
            mem_out   <= '0;
            opcode_q  <= OP_NOP;
            funct_q   <= '0;
        end else if (!stall) begin
            reg_we    <= NextRegWE;
            reg_waddr <= NextRegWAddr;
            din_src   <= NextDInSrc;
            pc4       <= NextPCPlusFour;
            alu_out   <= NextALUOut;
            fpu_out   <= NextFPUOut;
            mem_out   <= NextMEMDout;
            opcode_q  <= NextOpcode;
            funct_q   <= NextFunct;
        end
    end

    logic [DW-1:0] pipe_data;
    always_comb begin
        pipe_data = pc4;
        case (din_src)
            2'd0:    pipe_data = pc4;
            2'd1:    pipe_data = alu_out;
            2'd2:    pipe_data = fpu_out;
            default: pipe_data = mem_out;
        endcase
    end

    // ---------------- late-result queue ----------------
    logic [AW-1:0]     q_addr [QDEPTH];
    logic [DW-1:0]     q_data [QDEPTH];
    logic [QDEPTH-1:0] q_vld;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve;

    logic q_nonempty, ready_int, enq, deq, force_q, use_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign q_nonempty = (count != '0);
    // Readiness comes only from the registered count so the producer never
    // sees a combinational path through the dequeue decision.
    assign ready_int  = (count < CW'(QDEPTH));
    assign enq        = LateValid && ready_int;
    assign force_q    = q_nonempty && (starve == SW'(STARVE_MAX));
    assign use_q      = q_nonempty && (!reg_we || force_q);
    assign deq        = use_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_vld  <= '0;
            starve <= '0;
        end else begin
            if (enq) begin
                wr_ptr        <= ptr_inc(wr_ptr);
                q_vld[wr_ptr] <= 1'b1;
            end
            // enq and deq never target the same slot: that needs wr==rd,
            // i.e. empty (no deq) or full (no enq).
            if (deq) begin
                rd_ptr        <= ptr_inc(rd_ptr);
                q_vld[rd_ptr] <= 1'b0;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // Counts cycles the pipeline beat a non-empty queue.
            if (deq || !q_nonempty)
                starve <= '0;
            else if (reg_we && (starve != SW'(STARVE_MAX)))
                starve <= starve + 1'b1;
        end
    end

    // Entry payload needs no reset; q_vld and count define validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= LateAddr;
            q_data[wr_ptr] <= LateData;
        end
    end

    always_comb begin
        PendHit = 1'b0;
        for (int i = 0; i < QDEPTH; i++)
            if (q_vld[i] && (q_addr[i] == PendAddrQ))
                PendHit = 1'b1;
    end

    // ---------------- outputs ----------------
    assign LateReady    = ready_int && !reset;
    assign WBStallReq   = force_q && reg_we;
    assign RegWBWE      = reg_we || q_nonempty;
    assign RegWBSrcLate = use_q;
    assign RegWBAddr    = use_q ? q_addr[rd_ptr] : reg_waddr;
    assign RegWBData    = use_q ? q_data[rd_ptr] : pipe_data;
    assign Opcode       = opcode_q;
    assign Function     = funct_q;
    assign QueueCount   = count;

endmodule

// File: tb/tb_wb_late_merge_stage.sv
module tb_wb_late_merge_stage;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int QD = 4;
    localparam int SM = 3;
    localparam int CW = $clog2(QD+1);

    logic          clk = 1'b0;
    logic          reset, stall;
    logic          NextRegWE;
    logic [AW-1:0] NextRegWAddr;
    logic [1:0]    NextDInSrc;
    logic [DW-1:0] NextPCPlusFour, NextALUOut, NextFPUOut, NextMEMDout;
    logic [5:0]    NextOpcode, NextFunct;
    logic          LateValid;
    logic [AW-1:0] LateAddr;
    logic [DW-1:0] LateData;
    logic          LateReady;
    logic [AW-1:0] PendAddrQ;
    logic          PendHit, WBStallReq, RegWBWE, RegWBSrcLate;
    logic [AW-1:0] RegWBAddr;
    logic [DW-1:0] RegWBData;
    logic [5:0]    Opcode, Function;
    logic [CW-1:0] QueueCount;

    wb_late_merge_stage #(.DW(DW), .AW(AW), .QDEPTH(QD), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .NextRegWE(NextRegWE), .NextRegWAddr(NextRegWAddr), .NextDInSrc(NextDInSrc),
        .NextPCPlusFour(NextPCPlusFour), .NextALUOut(NextALUOut),
        .NextFPUOut(NextFPUOut), .NextMEMDout(NextMEMDout),
        .NextOpcode(NextOpcode), .NextFunct(NextFunct),
        .LateValid(LateValid), .LateAddr(LateAddr), .LateData(LateData),
        .LateReady(LateReady), .PendAddrQ(PendAddrQ), .PendHit(PendHit),
        .WBStallReq(WBStallReq), .RegWBWE(RegWBWE), .RegWBAddr(RegWBAddr),
        .RegWBData(RegWBData), .RegWBSrcLate(RegWBSrcLate),
        .Opcode(Opcode), .Function(Function), .QueueCount(QueueCount)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: stage contents plus a plain FIFO of late results and
    // a count of consecutive cycles the pipeline beat a waiting queue.
    typedef struct packed {
        logic                we;
        logic [AW-1:0]       wa;
        logic [1:0]          src;
        logic [3:0][DW-1:0]  v;     // 0=PC+4 1=ALU 2=FPU 3=MEM
        logic [5:0]          op;
        logic [5:0]          fn;
    } stage_t;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } late_t;

    stage_t ms;
    late_t  mq[$];
    int     mwins;
    logic   want_stall;
    logic   chk_en;

    function automatic logic m_force();
        return (mq.size() != 0) && (mwins == SM);
    endfunction

    function automatic logic m_useq();
        return (mq.size() != 0) && (!ms.we || m_force());
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_compare();
        int n;
        logic uq, hit;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        n  = mq.size();
        uq = m_useq();
        ea = ms.wa;
        ed = ms.v[ms.src];
        if (uq) begin
            ea = mq[0].a;
            ed = mq[0].d;
        end
        hit = 1'b0;
        foreach (mq[i]) if (mq[i].a == PendAddrQ) hit = 1'b1;
        chk("we",          64'(RegWBWE),      64'(ms.we || n != 0));
        chk("addr",        64'(RegWBAddr),    64'(ea));
        chk("data",        64'(RegWBData),    64'(ed));
        chk("src_late",    64'(RegWBSrcLate), 64'(uq));
        chk("stall_req",   64'(WBStallReq),   64'(m_force() && ms.we));
        chk("late_ready",  64'(LateReady),    64'(!reset && n < QD));
        chk("pend_hit",    64'(PendHit),      64'(hit));
        chk("queue_count", 64'(QueueCount),   64'(n));
        chk("opcode",      64'(Opcode),       64'(ms.op));
        chk("funct",       64'(Function),     64'(ms.fn));
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic tick();
        int   n;
        logic uq, acc;
        stall = want_stall || (m_force() && ms.we);
        #1;
        if (chk_en) model_compare();
        @(posedge clk);
        if (reset) begin
            ms    = '0;
            ms.op = 6'h15;
            mq.delete();
            mwins = 0;
        end else begin
            n   = mq.size();
            uq  = m_useq();
            acc = LateValid && (n < QD);
            if (uq) void'(mq.pop_front());
            if (acc) mq.push_back({LateAddr, LateData});
            if (uq || n == 0) mwins = 0;
            else if (ms.we && mwins < SM) mwins++;
            if (!stall) begin
                ms.we  = NextRegWE;
                ms.wa  = NextRegWAddr;
                ms.src = NextDInSrc;
                ms.v   = {NextMEMDout, NextFPUOut, NextALUOut, NextPCPlusFour};
                ms.op  = NextOpcode;
                ms.fn  = NextFunct;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset = 1'b0; want_stall = 1'b0; stall = 1'b0;
        NextRegWE = 1'b0; NextRegWAddr = '0; NextDInSrc = '0;
        NextPCPlusFour = '0; NextALUOut = '0; NextFPUOut = '0; NextMEMDout = '0;
        NextOpcode = '0; NextFunct = '0;
        LateValid = 1'b0; LateAddr = '0; LateData = '0; PendAddrQ = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        ms = '0; ms.op = 6'h15; mwins = 0;
        chk_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // T1: reset while the queue holds entries and has begun draining
        NextRegWE = 1'b1; NextRegWAddr = 6'd40; NextOpcode = 6'h01;
        tick();
        for (int i = 1; i <= 3; i++) begin
            LateValid = 1'b1; LateAddr = AW'(i); LateData = DW'(32'hA00 + i);
            tick();
        end
        LateValid = 1'b0; NextRegWE = 1'b0;
        tick();
        chk("t1_pre_count", 64'(QueueCount), 64'd3);
        reset = 1'b1;
        tick();
        tick();
        chk("t1_rst_we",     64'(RegWBWE),    64'd0);
        chk("t1_rst_opcode", 64'(Opcode),     64'h15);
        chk("t1_rst_count",  64'(QueueCount), 64'd0);
        chk("t1_rst_ready",  64'(LateReady),  64'd0);
        reset = 1'b0;
        #1;
        chk("t1_ready_after", 64'(LateReady), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_no_late_we", 64'(RegWBWE), 64'd0);
        end

        // T2: source mux and stall hold
        NextRegWE = 1'b1; NextRegWAddr = 6'd5;
        NextPCPlusFour = 32'h10; NextALUOut = 32'h20; NextFPUOut = 32'h30; NextMEMDout = 32'h40;
        for (int s = 0; s < 4; s++) begin
            NextDInSrc = 2'(s);
            tick();
            chk("t2_mux_data", 64'(RegWBData), 64'((s + 1) * 16));
            chk("t2_mux_addr", 64'(RegWBAddr), 64'd5);
        end
        want_stall = 1'b1;
        NextRegWAddr = 6'd9; NextDInSrc = 2'd0; NextPCPlusFour = 32'h99; NextOpcode = 6'h2A;
        tick();
        tick();
        chk("t2_hold_data", 64'(RegWBData), 64'h40);
        chk("t2_hold_addr", 64'(RegWBAddr), 64'd5);
        want_stall = 1'b0;

        // T3: fill to QDEPTH, lookup, held fifth offer
        do_reset();
        NextRegWE = 1'b1; NextRegWAddr = 6'd33;
        tick();
        for (int i = 1; i <= 4; i++) begin
            LateValid = 1'b1; LateAddr = AW'(i); LateData = DW'(32'h100 + i);
            tick();
        end
        chk("t3_full_count", 64'(QueueCount), 64'd4);
        chk("t3_full_ready", 64'(LateReady),  64'd0);
        PendAddrQ = 6'd3; #1;
        chk("t3_hit3", 64'(PendHit), 64'd1);
        PendAddrQ = 6'd9; #1;
        chk("t3_hit9", 64'(PendHit), 64'd0);
        LateAddr = 6'd5; LateData = 32'h105;
        tick();
        chk("t3_held_count", 64'(QueueCount), 64'd3);
        tick();
        chk("t3_taken_count", 64'(QueueCount), 64'd4);
        PendAddrQ = 6'd5; #1;
        chk("t3_hit5", 64'(PendHit), 64'd1);
        LateValid = 1'b0; NextRegWE = 1'b0;
        repeat (6) tick();
        chk("t3_drained", 64'(QueueCount), 64'd0);

        // T4: idle drain of two entries on consecutive cycles
        do_reset();
        LateValid = 1'b1; LateAddr = 6'd7; LateData = 32'hAA;
        tick();
        chk("t4_w1_late", 64'(RegWBSrcLate), 64'd1);
        chk("t4_w1_addr", 64'(RegWBAddr),    64'd7);
        chk("t4_w1_data", 64'(RegWBData),    64'hAA);
        LateAddr = 6'd8; LateData = 32'hBB;
        tick();
        chk("t4_w2_late", 64'(RegWBSrcLate), 64'd1);
        chk("t4_w2_addr", 64'(RegWBAddr),    64'd8);
        chk("t4_w2_data", 64'(RegWBData),    64'hBB);
        LateValid = 1'b0;
        tick();
        chk("t4_idle_we", 64'(RegWBWE), 64'd0);

        // T5: starvation forces the queue after SM pipeline wins
        do_reset();
        NextRegWE = 1'b1; NextRegWAddr = 6'd30; NextALUOut = 32'h3030; NextDInSrc = 2'd1;
        LateValid = 1'b1; LateAddr = 6'd12; LateData = 32'hC0FFEE;
        tick();
        LateValid = 1'b0;
        for (int i = 0; i < SM; i++) begin
            chk("t5_pipe_wins", 64'(RegWBSrcLate), 64'd0);
            chk("t5_no_stall",  64'(WBStallReq),   64'd0);
            chk("t5_pipe_addr", 64'(RegWBAddr),    64'd30);
            tick();
        end
        chk("t5_force_stall", 64'(WBStallReq),   64'd1);
        chk("t5_force_late",  64'(RegWBSrcLate), 64'd1);
        chk("t5_force_addr",  64'(RegWBAddr),    64'd12);
        chk("t5_force_data",  64'(RegWBData),    64'hC0FFEE);
        NextRegWAddr = 6'd40;
        tick();
        chk("t5_held_late", 64'(RegWBSrcLate), 64'd0);
        chk("t5_held_we",   64'(RegWBWE),      64'd1);
        chk("t5_held_addr", 64'(RegWBAddr),    64'd30);
        tick();
        chk("t5_next_addr", 64'(RegWBAddr), 64'd40);

        // T6: steady enqueue+dequeue at count=2 across pointer wrap
        do_reset();
        NextRegWE = 1'b1; NextRegWAddr = 6'd20;
        tick();
        LateValid = 1'b1; LateAddr = 6'd50; LateData = 32'h0;
        tick();
        NextRegWE = 1'b0;
        LateAddr = 6'd51; LateData = 32'h111;
        tick();
        for (int j = 0; j < 10; j++) begin
            chk("t6_count", 64'(QueueCount),   64'd2);
            chk("t6_late",  64'(RegWBSrcLate), 64'd1);
            chk("t6_addr",  64'(RegWBAddr),    64'(50 + j));
            chk("t6_data",  64'(RegWBData),    64'(j * 32'h111));
            LateAddr = AW'(52 + j); LateData = DW'((j + 2) * 32'h111);
            tick();
        end
        LateValid = 1'b0;

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            reset          = ($urandom_range(0, 79) == 0);
            want_stall     = ($urandom_range(0, 5) == 0);
            NextRegWE      = ($urandom_range(0, 2) != 0);
            NextRegWAddr   = AW'($urandom);
            NextDInSrc     = 2'($urandom);
            NextPCPlusFour = $urandom;
            NextALUOut     = $urandom;
            NextFPUOut     = $urandom;
            NextMEMDout    = $urandom;
            NextOpcode     = 6'($urandom);
            NextFunct      = 6'($urandom);
            LateValid      = 1'($urandom_range(0, 1));
            LateAddr       = AW'($urandom_range(0, 7));
            LateData       = $urandom;
            PendAddrQ      = AW'($urandom_range(0, 7));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
